// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared state/op encodings for the HI/LO multiply/divide sequencer
// Contents: state_t (S_IDLE/S_MUL/S_DIV/S_FIX), op_t (OP_MULT/OP_MULTU/OP_DIV/OP_DIVU),
//           op classification helpers.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    function automatic logic op_is_signed(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_absneg.sv
// rtl/muldiv_ctrl_absneg.sv - conditional two's-complement negation of a WIDTH-bit value
// Ports: value (in, WIDTH), neg (in, 1: negate when high), result (out, WIDTH).
module muldiv_ctrl_absneg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - MIPS HI/LO multiply/divide sequencer with ID stall generation
// Parameters: WIDTH (operand/HI/LO width), CNT_W (iteration counter width, 2^CNT_W > WIDTH).
// Ports: clk, rst (sync, active-high); request strobes mult/multu/div/divu/mthi/mtlo/mfhi/mflo;
//        operands a (rs), b (rt); outputs hi, lo, rdata (mfhi ? hi : lo), busy, stall, dbz.
// Option: define MULDIV_EARLY_OUT_EN to skip iteration when the result is trivially zero.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult,
    input  logic             multu,
    input  logic             div,
    input  logic             divu,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             mfhi,
    input  logic             mflo,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             stall,
    output logic             dbz
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    op_t                op;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;    // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   dvsr;   // multiplicand or divisor magnitude
    logic               neg_lo; // product / quotient sign
    logic               neg_hi; // remainder sign

    logic       start;
    logic       any_req;
    op_t        sel_op;
    logic       sgn;
    logic       early;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign start   = mult | multu | div | divu;
    assign any_req = start | mthi | mtlo | mfhi | mflo;
    assign busy    = (state != S_IDLE);
    assign stall   = busy & any_req;
    assign rdata   = mfhi ? hi : lo;

    always_comb begin
        sel_op = OP_DIVU;
        if (mult)       sel_op = OP_MULT;
        else if (multu) sel_op = OP_MULTU;
        else if (div)   sel_op = OP_DIV;
    end

    assign sgn = op_is_signed(sel_op);

`ifdef MULDIV_EARLY_OUT_EN
    assign early = op_is_div(sel_op) ? ((a == '0) && (b != '0)) : ((a == '0) || (b == '0));
`else
    assign early = 1'b0;
`endif

    muldiv_ctrl_absneg #(.WIDTH(WIDTH)) u_abs_a (
        .value(a), .neg(sgn & a[WIDTH-1]), .result(abs_a));
    muldiv_ctrl_absneg #(.WIDTH(WIDTH)) u_abs_b (
        .value(b), .neg(sgn & b[WIDTH-1]), .result(abs_b));
    muldiv_ctrl_absneg #(.WIDTH(2*WIDTH)) u_prod_fix (
        .value(acc), .neg(neg_lo), .result(prod_fix));
    muldiv_ctrl_absneg #(.WIDTH(WIDTH)) u_quo_fix (
        .value(acc[WIDTH-1:0]), .neg(neg_lo), .result(quo_fix));
    muldiv_ctrl_absneg #(.WIDTH(WIDTH)) u_rem_fix (
        .value(acc[2*WIDTH-1:WIDTH]), .neg(neg_hi), .result(rem_fix));

    // Shift-add: add multiplicand when the current multiplier LSB is set, then shift right.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvsr} : '0);
    // Restoring step: {remainder, next dividend bit} minus divisor; MSB set means restore.
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dvsr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op     <= OP_MULT;
            cnt    <= '0;
            acc    <= '0;
            dvsr   <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            dbz    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op     <= sel_op;
                        cnt    <= '0;
                        // A trivially-zero result needs no iteration: a zero accumulator
                        // stays zero through the sign fixup.
                        acc    <= early ? '0 : {{WIDTH{1'b0}}, abs_a};
                        dvsr   <= abs_b;
                        neg_lo <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi <= sgn & a[WIDTH-1];
                        dbz    <= op_is_div(sel_op) && (b == '0);
                        if (early)                  state <= S_FIX;
                        else if (op_is_div(sel_op)) state <= S_DIV;
                        else                        state <= S_MUL;
                    end else if (mthi | mtlo) begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                        dbz <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= S_FIX;
                end
                S_DIV: begin
                    if (!div_trial[WIDTH])
                        acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else
                        acc <= {acc[2*WIDTH-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= S_FIX;
                end
                S_FIX: begin
                    if (op_is_div(op)) begin
                        // Divide by zero iterates to remainder |a|, so the sign fixup yields HI=a;
                        // only the quotient needs forcing to all-ones.
                        lo <= dbz ? '1 : quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    cnt   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          mult, multu, div, divu, mthi, mtlo, mfhi, mflo;
    logic [W-1:0]  a, b;
    logic [W-1:0]  hi, lo, rdata;
    logic          busy, stall, dbz;

    int            checks = 0;
    int            errors = 0;

    logic [W-1:0]  m_hi, m_lo;
    logic          m_dbz;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .mult(mult), .multu(multu), .div(div), .divu(divu),
        .mthi(mthi), .mtlo(mtlo), .mfhi(mfhi), .mflo(mflo),
        .a(a), .b(b),
        .hi(hi), .lo(lo), .rdata(rdata),
        .busy(busy), .stall(stall), .dbz(dbz)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_strobes();
        mult = 0; multu = 0; div = 0; divu = 0;
        mthi = 0; mtlo = 0; mfhi = 0; mflo = 0;
    endtask

    // kind: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
    task automatic model_op(input int kind, input logic [W-1:0] oa, input logic [W-1:0] ob);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(oa));
        sb = longint'($signed(ob));
        case (kind)
            0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; m_dbz = 0; end
            1: begin p = {32'b0, oa} * {32'b0, ob}; {m_hi, m_lo} = p; m_dbz = 0; end
            2, 3: begin
                if (ob == 0) begin
                    m_lo = '1; m_hi = oa; m_dbz = 1;
                end else begin
                    if (kind == 2) begin q = sa / sb; r = sa % sb; end
                    else begin q = longint'(oa) / longint'(ob); r = longint'(oa) % longint'(ob); end
                    m_lo = q[31:0]; m_hi = r[31:0]; m_dbz = 0;
                end
            end
            4: begin m_hi = oa; m_dbz = 0; end
            5: begin m_lo = oa; m_dbz = 0; end
            default: ;
        endcase
    endtask

    function automatic int exp_len(input int kind, input logic [W-1:0] oa, input logic [W-1:0] ob);
`ifdef MULDIV_EARLY_OUT_EN
        if (kind < 2 && (oa == 0 || ob == 0)) return 1;
        if (kind >= 2 && oa == 0 && ob != 0) return 1;
`endif
        return W + 1;
    endfunction

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input int kind, input logic [W-1:0] oa, input logic [W-1:0] ob);
        int n;
        @(negedge clk);
        a = oa; b = ob;
        case (kind)
            0: mult = 1;  1: multu = 1; 2: div = 1;  3: divu = 1;
            4: mthi = 1;  5: mtlo = 1;  6: mfhi = 1; default: mflo = 1;
        endcase
        #1;
        check("stall_idle", 64'(stall), 64'(0));
        if (kind == 6) check("rdata_hi", 64'(rdata), 64'(m_hi));
        if (kind == 7) check("rdata_lo", 64'(rdata), 64'(m_lo));
        @(negedge clk);
        clear_strobes();
        model_op(kind, oa, ob);
        if (kind < 4) begin
            wait_idle(n);
            check($sformatf("busy_len k%0d", kind), 64'(n), 64'(exp_len(kind, oa, ob)));
        end
        check($sformatf("hi k%0d a=%h b=%h", kind, oa, ob), 64'(hi), 64'(m_hi));
        check($sformatf("lo k%0d a=%h b=%h", kind, oa, ob), 64'(lo), 64'(m_lo));
        if (kind < 6) check($sformatf("dbz k%0d", kind), 64'(dbz), 64'(m_dbz));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int n, k;
        rst = 1; a = 0; b = 0;
        clear_strobes();
        m_hi = 0; m_lo = 0; m_dbz = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_dbz", 64'(dbz), 64'(0));
        rst = 0;

        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t1_hi_const", 64'(hi), 64'(32'hFFFF_FFFE));
        check("t1_lo_const", 64'(lo), 64'(32'h0000_0001));
        run_op(0, -32'sd3, 32'd7);
        check("t2_mult_lo_const", 64'(lo), 64'(32'hFFFF_FFEB));
        run_op(2, -32'sd7, 32'd2);
        check("t2_div_lo_const", 64'(lo), 64'(32'hFFFF_FFFD));
        run_op(3, 32'h1234, 32'h0);
        check("t3_dbz_const", 64'(dbz), 64'(1));
        run_op(5, 32'hCAFE_F00D, 32'h0);
        run_op(2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2, 32'h8000_0005, 32'h0);
        run_op(0, 32'h1234, 32'h0);
        run_op(2, 32'h0, 32'h9);

        // mflo reissued while a divu runs: held off until the first idle cycle.
        @(negedge clk);
        a = 32'h00AB_CDEF; b = 32'h13; divu = 1;
        @(negedge clk);
        divu = 0;
        model_op(3, 32'h00AB_CDEF, 32'h13);
        @(negedge clk);
        mflo = 1;
        #1;
        n = 0; k = 0;
        while (busy && k < 200) begin
            if (stall) n++;
            k++;
            @(negedge clk);
            #1;
        end
        check("t4_stall_len", 64'(n), 64'(exp_len(3, 32'h00AB_CDEF, 32'h13) - 1));
        check("t4_stall_rel", 64'(stall), 64'(0));
        check("t4_rdata", 64'(rdata), 64'(m_lo));
        @(negedge clk);
        mflo = 0;

        // Reset in the middle of a multiply.
        @(negedge clk);
        a = 32'h5; b = 32'h9; mult = 1;
        @(negedge clk);
        mult = 0;
        repeat (9) @(negedge clk);
        check("t5_busy_pre", 64'(busy), 64'(1));
        rst = 1;
        @(negedge clk);
        rst = 0;
        m_hi = 0; m_lo = 0; m_dbz = 0;
        mflo = 1;
        #1;
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_stall", 64'(stall), 64'(0));
        check("t5_hi", 64'(hi), 64'(0));
        check("t5_lo", 64'(lo), 64'(0));
        check("t5_dbz", 64'(dbz), 64'(0));
        @(negedge clk);
        mflo = 0;

        run_op(4, 32'hDEAD_BEEF, 32'h0);
        check("t6_mthi_const", 64'(hi), 64'(32'hDEAD_BEEF));

        // mult and div strobed together: mult has priority.
        @(negedge clk);
        a = 32'hFFFF_FFFA; b = 32'h7; mult = 1; div = 1;
        @(negedge clk);
        clear_strobes();
        model_op(0, 32'hFFFF_FFFA, 32'h7);
        wait_idle(n);
        check("t6_prio_len", 64'(n), 64'(W + 1));
        check("t6_prio_hi", 64'(hi), 64'(m_hi));
        check("t6_prio_lo", 64'(lo), 64'(m_lo));

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 7)), pick(), pick());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
